// File: rtl/flags_unit.sv
// flags_unit
//   Processor status register (N V D I Z C) plus the flag-control strobes
//   that the decoder and random logic drive into it. Adds to the classic
//   6502 behaviour:
//     - optional decimal mode. When it is disabled, D is still stored but
//       D_EFF stays low.
//     - an I-flag pipeline that models the one-instruction mask latency
//       of CLI, SEI and PLP.
//     - a synchronised SO pin. A falling edge on it sets V.
//     - READY stalling of architectural flag writes.
//
// Ports
//   PHI0      clock; every state change happens on its rising edge
//   RES       synchronous active-high reset
//   READY     1 = flag writes allowed, 0 = writes stalled (SO still acts)
//   DB        internal data bus
//   ACR, AVR  ALU carry and overflow outputs
//   IR5       opcode bit 5; the value used by SEC/CLC, SEI/CLI, SED/CLD
//   P_LD      load N,V,D,I,Z,C from DB[7,6,3,2,1,0]
//   NZ_DB     N <= DB[7], Z <= (DB == 0)
//   C_ACR     C <= ACR
//   V_AVR     V <= AVR
//   BIT_OP    N <= DB[7], V <= DB[6]
//   C_IR5, I_IR5, D_IR5   C / I / D <= IR5
//   V_CLR     V <= 0
//   SO        asynchronous set-overflow pin
//   BRK_PUSH  value shown on P_OUT[4]
//   P_OUT     {N,V,1,BRK_PUSH,D,I,Z,C}
//   I_MASK    I flag delayed by I_DELAY stages
//   D_EFF     D & DECIMAL_EN
//   C_OUT     C flag, used as the ALU carry-in

module flags_unit #(
    parameter bit         DECIMAL_EN = 1'b1,
    parameter int         I_DELAY    = 1,      // 0..3
    parameter int         SO_SYNC    = 2,      // >= 2
    parameter logic [7:0] RESET_P    = 8'h04
) (
    input  logic       PHI0,
    input  logic       RES,
    input  logic       READY,
    input  logic [7:0] DB,
    input  logic       ACR,
    input  logic       AVR,
    input  logic       IR5,
    input  logic       P_LD,
    input  logic       NZ_DB,
    input  logic       C_ACR,
    input  logic       V_AVR,
    input  logic       BIT_OP,
    input  logic       C_IR5,
    input  logic       I_IR5,
    input  logic       D_IR5,
    input  logic       V_CLR,
    input  logic       SO,
    input  logic       BRK_PUSH,
    output logic [7:0] P_OUT,
    output logic       I_MASK,
    output logic       D_EFF,
    output logic       C_OUT
);

    // ------------------------------------------------------------------
    // Flag registers
    // ------------------------------------------------------------------
    logic n_flag, v_flag, d_flag, i_flag, z_flag, c_flag;
    logic n_nxt,  v_nxt,  d_nxt,  i_nxt,  z_nxt,  c_nxt;

    // ------------------------------------------------------------------
    // SO synchroniser and falling-edge detector.
    // so_dly holds the previous synchronised value. Every stage resets to
    // 1, so releasing reset can never look like a falling edge, and any
    // edge still in flight when reset arrives is dropped.
    // ------------------------------------------------------------------
    logic [SO_SYNC-1:0] so_sync;
    logic               so_dly;
    logic               so_edge;

    always_ff @(posedge PHI0) begin
        if (RES) begin
            so_sync <= '1;
            so_dly  <= 1'b1;
        end else begin
            so_sync <= {so_sync[SO_SYNC-2:0], SO};
            so_dly  <= so_sync[SO_SYNC-1];
        end
    end

    assign so_edge = so_dly & ~so_sync[SO_SYNC-1];

    // ------------------------------------------------------------------
    // Next-state selection.
    // When READY is high, P_LD overrides the individual strobes.
    // so_edge is applied last, so it beats every other V source, even
    // while the core is stalled.
    // ------------------------------------------------------------------
    always_comb begin
        n_nxt = n_flag;
        v_nxt = v_flag;
        d_nxt = d_flag;
        i_nxt = i_flag;
        z_nxt = z_flag;
        c_nxt = c_flag;

        if (READY) begin
            if (P_LD) begin
                n_nxt = DB[7];
                v_nxt = DB[6];
                d_nxt = DB[3];
                i_nxt = DB[2];
                z_nxt = DB[1];
                c_nxt = DB[0];
            end else begin
                // NZ_DB and BIT_OP both take DB[7], so they never conflict.
                if (NZ_DB || BIT_OP) n_nxt = DB[7];
                if (NZ_DB)           z_nxt = (DB == 8'h00);

                if (V_CLR)       v_nxt = 1'b0;
                else if (V_AVR)  v_nxt = AVR;
                else if (BIT_OP) v_nxt = DB[6];

                if (C_ACR)      c_nxt = ACR;
                else if (C_IR5) c_nxt = IR5;

                if (I_IR5) i_nxt = IR5;
                if (D_IR5) d_nxt = IR5;
            end
        end

        if (so_edge) v_nxt = 1'b1;
    end

    always_ff @(posedge PHI0) begin
        if (RES) begin
            n_flag <= RESET_P[7];
            v_flag <= RESET_P[6];
            d_flag <= RESET_P[3];
            i_flag <= RESET_P[2];
            z_flag <= RESET_P[1];
            c_flag <= RESET_P[0];
        end else begin
            n_flag <= n_nxt;
            v_flag <= v_nxt;
            d_flag <= d_nxt;
            i_flag <= i_nxt;
            z_flag <= z_nxt;
            c_flag <= c_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt-mask pipeline.
    // This pipeline ignores READY and shifts every cycle.
    // ------------------------------------------------------------------
    generate
        if (I_DELAY == 0) begin : g_no_idly
            assign I_MASK = i_flag;
        end else begin : g_idly
            logic [I_DELAY-1:0] i_pipe;

            always_ff @(posedge PHI0) begin
                if (RES) begin
                    i_pipe <= {I_DELAY{RESET_P[2]}};
                end else begin
                    i_pipe[0] <= i_flag;
                    for (int k = 1; k < I_DELAY; k++)
                        i_pipe[k] <= i_pipe[k-1];
                end
            end

            assign I_MASK = i_pipe[I_DELAY-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign P_OUT = {n_flag, v_flag, 1'b1, BRK_PUSH, d_flag, i_flag, z_flag, c_flag};
    assign D_EFF = d_flag & DECIMAL_EN;
    assign C_OUT = c_flag;

endmodule

// File: tb/tb_flags_unit.sv
// Self-checking bench for flags_unit.
// Two instances receive the same stimulus: one with decimal mode off and
// one with it on. A reference model in the bench predicts the outputs at
// every rising edge and pushes them onto a queue. The values are popped
// and compared 1 ns after the edge. Directed steps also check the
// important cases against fixed constants.

module tb_flags_unit;

    localparam int         I_DELAY = 1;
    localparam int         SO_SYNC = 2;
    localparam logic [7:0] RESET_P = 8'h04;

    logic       PHI0 = 1'b0;
    logic       RES, READY, ACR, AVR, IR5, P_LD, NZ_DB, C_ACR, V_AVR, BIT_OP;
    logic       C_IR5, I_IR5, D_IR5, V_CLR, SO, BRK_PUSH;
    logic [7:0] DB;
    logic [7:0] p_out0, p_out1;
    logic       i_mask0, i_mask1, d_eff0, d_eff1, c_out0, c_out1;

    always #5 PHI0 = ~PHI0;

    flags_unit #(.DECIMAL_EN(1'b0), .I_DELAY(I_DELAY), .SO_SYNC(SO_SYNC), .RESET_P(RESET_P)) dut (
        .PHI0(PHI0), .RES(RES), .READY(READY), .DB(DB), .ACR(ACR), .AVR(AVR), .IR5(IR5),
        .P_LD(P_LD), .NZ_DB(NZ_DB), .C_ACR(C_ACR), .V_AVR(V_AVR), .BIT_OP(BIT_OP),
        .C_IR5(C_IR5), .I_IR5(I_IR5), .D_IR5(D_IR5), .V_CLR(V_CLR), .SO(SO),
        .BRK_PUSH(BRK_PUSH), .P_OUT(p_out0), .I_MASK(i_mask0), .D_EFF(d_eff0), .C_OUT(c_out0));

    flags_unit #(.DECIMAL_EN(1'b1), .I_DELAY(I_DELAY), .SO_SYNC(SO_SYNC), .RESET_P(RESET_P)) dut_dec (
        .PHI0(PHI0), .RES(RES), .READY(READY), .DB(DB), .ACR(ACR), .AVR(AVR), .IR5(IR5),
        .P_LD(P_LD), .NZ_DB(NZ_DB), .C_ACR(C_ACR), .V_AVR(V_AVR), .BIT_OP(BIT_OP),
        .C_IR5(C_IR5), .I_IR5(I_IR5), .D_IR5(D_IR5), .V_CLR(V_CLR), .SO(SO),
        .BRK_PUSH(BRK_PUSH), .P_OUT(p_out1), .I_MASK(i_mask1), .D_EFF(d_eff1), .C_OUT(c_out1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic                m_n, m_v, m_d, m_i, m_z, m_c;
    logic [3:0]          m_ip;
    logic [SO_SYNC-1:0]  m_so;
    logic                m_sod;

    typedef struct packed {
        logic [7:0] p;
        logic       im;
        logic       de1;
        logic       co;
    } exp_t;

    exp_t sb[$];

    task automatic model_step();
        logic fall;
        fall = m_sod & ~m_so[SO_SYNC-1];
        if (RES) begin
            {m_n, m_v} = RESET_P[7:6];
            {m_d, m_i, m_z, m_c} = RESET_P[3:0];
            m_ip  = {4{RESET_P[2]}};
            m_so  = '1;
            m_sod = 1'b1;
        end else begin
            for (int k = I_DELAY - 1; k > 0; k--) m_ip[k] = m_ip[k-1];
            m_ip[0] = m_i;
            m_sod = m_so[SO_SYNC-1];
            for (int k = SO_SYNC - 1; k > 0; k--) m_so[k] = m_so[k-1];
            m_so[0] = SO;
            if (READY) begin
                if (P_LD) begin
                    {m_n, m_v} = DB[7:6];
                    {m_d, m_i, m_z, m_c} = DB[3:0];
                end else begin
                    if (NZ_DB) begin m_n = DB[7]; m_z = (DB == 8'h00); end
                    if (BIT_OP) m_n = DB[7];
                    if (V_CLR) m_v = 1'b0;
                    else if (V_AVR) m_v = AVR;
                    else if (BIT_OP) m_v = DB[6];
                    if (C_ACR) m_c = ACR;
                    else if (C_IR5) m_c = IR5;
                    if (I_IR5) m_i = IR5;
                    if (D_IR5) m_d = IR5;
                end
            end
            if (fall) m_v = 1'b1;
        end
    endtask

    // One clock: the model steps at the edge and its expectation is queued.
    // The queue is popped and compared against both instances 1 ns later.
    task automatic cyc();
        exp_t e;
        @(posedge PHI0);
        model_step();
        e.p   = {m_n, m_v, 1'b1, BRK_PUSH, m_d, m_i, m_z, m_c};
        e.im  = m_ip[I_DELAY-1];
        e.de1 = m_d;
        e.co  = m_c;
        sb.push_back(e);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 8'd0, 8'd1);
        end else begin
            e = sb.pop_front();
            chk("p_out",      p_out0,          e.p);
            chk("p_out_dec",  p_out1,          e.p);
            chk("i_mask",     {7'd0, i_mask0}, {7'd0, e.im});
            chk("i_mask_dec", {7'd0, i_mask1}, {7'd0, e.im});
            chk("d_eff",      {7'd0, d_eff0},  8'd0);
            chk("d_eff_dec",  {7'd0, d_eff1},  {7'd0, e.de1});
            chk("c_out",      {7'd0, c_out0},  {7'd0, e.co});
            chk("c_out_dec",  {7'd0, c_out1},  {7'd0, e.co});
        end
    endtask

    task automatic idle();
        P_LD = 0; NZ_DB = 0; C_ACR = 0; V_AVR = 0; BIT_OP = 0;
        C_IR5 = 0; I_IR5 = 0; D_IR5 = 0; V_CLR = 0;
        ACR = 0; AVR = 0; IR5 = 0; DB = 8'h00;
    endtask

    initial begin
        idle();
        RES = 1; READY = 1; SO = 1; BRK_PUSH = 0;
        m_n = 0; m_v = 0; m_d = 0; m_i = 0; m_z = 0; m_c = 0;
        m_ip = '0; m_so = '1; m_sod = 1;

        // Reset for 2 cycles
        cyc(); cyc();
        chk("rst_p_out", p_out0, 8'h24);
        chk("rst_i_mask", {7'd0, i_mask0}, 8'd1);
        chk("rst_c_out", {7'd0, c_out0}, 8'd0);
        RES = 0;

        // PLP: load C3. I_MASK falls 2 edges after the write.
        DB = 8'hC3; P_LD = 1;
        cyc();
        chk("plp_p_out", p_out0, 8'hE3);
        chk("plp_imask_e1", {7'd0, i_mask0}, 8'd1);
        idle();
        cyc();
        chk("plp_imask_e2", {7'd0, i_mask0}, 8'd0);

        // V_CLR beats V_AVR
        V_CLR = 1; V_AVR = 1; AVR = 1;
        cyc();
        chk("vclr_prio", {7'd0, p_out0[6]}, 8'd0);
        idle();

        // C_ACR beats C_IR5
        C_ACR = 1; ACR = 0; C_IR5 = 1; IR5 = 1;
        cyc();
        chk("cacr_prio", {7'd0, p_out0[0]}, 8'd0);
        idle();

        // Clear Z, then confirm a stalled NZ_DB write is ignored
        NZ_DB = 1; DB = 8'h80;
        cyc();
        chk("nz_z0", {7'd0, p_out0[1]}, 8'd0);
        READY = 0; DB = 8'h00;
        cyc();
        chk("stall_z", {7'd0, p_out0[1]}, 8'd0);
        idle();

        // SO falling edge while stalled with V_CLR held
        V_CLR = 1; SO = 0;
        cyc();
        cyc();
        chk("so_v_early", {7'd0, p_out0[6]}, 8'd0);
        cyc();
        chk("so_v_set", {7'd0, p_out0[6]}, 8'd1);
        READY = 1;                 // CLV takes effect now
        cyc();
        chk("so_clv", {7'd0, p_out0[6]}, 8'd0);
        V_CLR = 0;
        for (int k = 0; k < 3; k++) cyc();
        chk("so_hold_low", {7'd0, p_out0[6]}, 8'd0);
        SO = 1;
        cyc();

        // Decimal mode
        D_IR5 = 1; IR5 = 1;
        cyc();
        chk("dec_p3", {7'd0, p_out0[3]}, 8'd1);
        chk("dec_off_deff", {7'd0, d_eff0}, 8'd0);
        chk("dec_on_deff", {7'd0, d_eff1}, 8'd1);
        idle();

        // Mid-op reset with P_LD and a pending SO edge
        SO = 0;
        cyc();
        RES = 1; P_LD = 1; DB = 8'hFF; SO = 1;
        cyc();
        chk("midrst_p_out", p_out0, 8'h24);
        RES = 0; idle();
        for (int k = 0; k < 4; k++) cyc();
        chk("midrst_v", {7'd0, p_out0[6]}, 8'd0);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            RES      = ($urandom_range(39) == 0);
            READY    = ($urandom_range(3) != 0);
            DB       = ($urandom_range(4) == 0) ? 8'h00 : 8'($urandom);
            ACR      = 1'($urandom); AVR    = 1'($urandom); IR5   = 1'($urandom);
            P_LD     = ($urandom_range(7) == 0);
            NZ_DB    = 1'($urandom); C_ACR  = 1'($urandom); V_AVR = 1'($urandom);
            BIT_OP   = 1'($urandom); C_IR5  = 1'($urandom); I_IR5 = 1'($urandom);
            D_IR5    = 1'($urandom); V_CLR  = 1'($urandom);
            BRK_PUSH = 1'($urandom);
            if ($urandom_range(4) == 0) SO = ~SO;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
